// File: rtl/cv32e40p_obi_instr_responder.sv
// Fixed-latency OBI instruction responder: grants fetch requests, reads a synchronous
// word memory and returns one in-order {rdata, err} response per grant after LATENCY cycles.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MEM_AW          = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              stall_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [29:0]        word;
  logic               oor;
  logic               accept;
  logic [CW-1:0]      cnt_q;
  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] err_pipe;
  logic [31:0]        raw_data;
  logic               unused_addr;

  assign word        = addr_i[31:2];
  assign unused_addr = ^addr_i[1:0];
  // Compare the whole word index so aliased high addresses still flag an error.
  assign oor         = {2'b00, word} >= 32'(MEM_WORDS);

  // Full blocks the grant even in a cycle that also retires a response.
  assign gnt_o      = req_i && !stall_i && (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept     = req_i && gnt_o;
  assign mem_req_o  = accept && !oor;
  assign mem_addr_o = word[MEM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      err_pipe[0] <= accept && oor;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_pass
      assign raw_data = mem_rdata_i;
    end else begin : g_dat
      // Stage 1 holds the memory word read on the accept edge.
      logic [LATENCY-1:1][31:0] dat_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dat_q <= '0;
        end else begin
          dat_q[1] <= mem_rdata_i;
          for (int i = 2; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
        end
      end
      assign raw_data = dat_q[LATENCY-1];
    end
  endgenerate

  assign rvalid_o = vld_pipe[LATENCY-1];
  assign err_o    = rvalid_o && err_pipe[LATENCY-1];
  assign rdata_o  = err_o ? 32'h0 : raw_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      unique case ({accept, rvalid_o})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Bench: three responder configurations share one stimulus stream and are checked
// against a queue-based model of accepted fetches plus directed table and corner sequences.
module tb_cv32e40p_obi_instr_responder;
  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 3, 3};
  localparam int MXO [NI] = '{2, 3, 1};
  localparam int MW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic stall = 1'b0;
  logic [31:0] addr = 32'h0;

  logic [NI-1:0]        gnt, rvalid, err, mem_req;
  logic [NI-1:0][31:0]  rdata;
  logic [NI-1:0][9:0]   mem_addr;
  logic [NI-1:0][3:0]   cnt_w;
  logic [31:0]          mem [MW];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    logic [31:0] rd_q;
    cv32e40p_obi_instr_responder #(
      .LATENCY(LAT[g]), .MAX_OUTSTANDING(MXO[g]), .MEM_WORDS(MW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[g]), .addr_i(addr),
      .stall_i(stall), .rvalid_o(rvalid[g]), .rdata_o(rdata[g]), .err_o(err[g]),
      .mem_req_o(mem_req[g]), .mem_addr_o(mem_addr[g]), .mem_rdata_i(rd_q)
    );
    always @(posedge clk) if (mem_req[g]) rd_q <= mem[mem_addr[g]];
    assign cnt_w[g] = 4'(u_dut.cnt_q);
  end

  typedef struct { int t; bit err; logic [31:0] data; } rsp_t;
  typedef struct { bit req; bit stall; logic [31:0] addr;
                   bit gnt; bit rv; bit err; logic [31:0] data; } vec_t;

  rsp_t q [NI][$];
  vec_t tbl [6];
  vec_t cur;
  bit   t_en;
  int   e, nvec, nfail;
  bit   pend [NI];
  bit   pend_oor;
  logic [31:0] pend_addr;
  logic [NI-1:0] act_gnt, act_rv;

  function automatic logic [31:0] memval(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0001_0003);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", nm, act, exp, e);
    end
  endtask

  // Model: an accept at edge t is visible during the cycle after edge t+L-1
  // and stays outstanding until edge t+L.
  task automatic model_check();
    bit oor, eg, ev;
    oor = (addr >> 2) >= 32'(MW);
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) q[g].delete();
      while (q[g].size() > 0 && q[g][0].t + LAT[g] <= e) void'(q[g].pop_front());
      eg = req && !stall && (q[g].size() < MXO[g]);
      ev = rst_n && q[g].size() > 0 && (q[g][0].t + LAT[g] - 1 == e);
      chk($sformatf("gnt%0d", g), 32'(gnt[g]), 32'(eg));
      chk($sformatf("rvalid%0d", g), 32'(rvalid[g]), 32'(ev));
      chk($sformatf("err%0d", g), 32'(err[g]), ev ? 32'(q[g][0].err) : 32'h0);
      if (ev) chk($sformatf("rdata%0d", g), rdata[g], q[g][0].data);
      else if (!rst_n && LAT[g] > 1) chk($sformatf("rst_rdata%0d", g), rdata[g], 32'h0);
      chk($sformatf("mem_req%0d", g), 32'(mem_req[g]), 32'(eg && !oor));
      if (eg && !oor) chk($sformatf("mem_addr%0d", g), 32'(mem_addr[g]), (addr >> 2) & 32'h3FF);
      chk($sformatf("cnt%0d", g), 32'(cnt_w[g]), 32'(q[g].size()));
      pend[g] = eg && rst_n;
    end
    act_gnt = gnt;
    act_rv = rvalid;
    pend_oor = oor;
    pend_addr = addr;
    if (t_en) begin
      chk("tbl_gnt", 32'(gnt[0]), 32'(cur.gnt));
      chk("tbl_rvalid", 32'(rvalid[0]), 32'(cur.rv));
      if (cur.rv) begin
        chk("tbl_err", 32'(err[0]), 32'(cur.err));
        chk("tbl_rdata", rdata[0], cur.data);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    e++;
    for (int g = 0; g < NI; g++)
      if (pend[g]) q[g].push_back('{t: e, err: pend_oor,
                                     data: pend_oor ? 32'h0 : mem[pend_addr[11:2]]});
    #1;
  endtask

  task automatic idle(int n);
    req = 1'b0; stall = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n, idx, cg, cr;
    nvec = 0; nfail = 0; e = 0; t_en = 1'b0;
    for (int i = 0; i < MW; i++) mem[i] = memval(i);
    // Directed rows for the LATENCY=1, MAX_OUTSTANDING=2 instance.
    tbl[0] = '{1'b1, 1'b0, 32'h10,   1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h14,   1'b1, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h14,   1'b0, 1'b1, 1'b0, memval(5)};
    tbl[4] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h20,   1'b0, 1'b0, 1'b0, 32'h0};

    idle(3);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      cur = tbl[i];
      req = cur.req; stall = cur.stall; addr = cur.addr;
      t_en = 1'b1;
      cycle();
      t_en = 1'b0;
    end

    // Streaming 8 fetches on LATENCY=3/MAX=3: the full rule yields 3 grants per 4 cycles.
    idle(6);
    idx = 0; n = 0;
    while (idx < 8 && n < 40) begin
      req = 1'b1; addr = 32'(idx * 4);
      cycle();
      n++;
      if (act_gnt[1]) idx++;
    end
    chk("stream_cycles", 32'(n), 32'd10);
    idle(6);

    // LATENCY=3/MAX=1: one grant every LATENCY+1 cycles.
    req = 1'b1; addr = 32'h40; cg = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (act_gnt[2]) cg++;
    end
    chk("throttle_grants", 32'(cg), 32'd4);
    idle(6);

    // Stall mid-stream: no grants, in-flight responses still arrive.
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = 32'(32'h80 + i * 4);
      cycle();
    end
    stall = 1'b1; cg = 0; cr = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      cg += int'(act_gnt != '0);
      if (act_rv[1]) cr++;
    end
    chk("stall_grants", 32'(cg), 32'd0);
    chk("stall_rvalids", 32'(cr), 32'd3);
    idle(6);

    // Reset with two fetches outstanding: nothing is answered afterwards.
    for (int i = 0; i < 2; i++) begin
      req = 1'b1; addr = 32'(32'h100 + i * 4);
      cycle();
    end
    req = 1'b0;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cr = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cr += int'(act_rv != '0);
    end
    chk("post_reset_rvalids", 32'(cr), 32'd0);
    chk("post_reset_cnt", 32'(cnt_w[1]), 32'd0);

    // Random traffic with occasional out-of-range addresses and resets.
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      addr  = ($urandom_range(0, 9) == 0) ? $urandom
                                          : ((32'($urandom_range(0, MW - 1)) << 2) | ($urandom & 32'h3));
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
